axi_master_wrapper: RTL and testbench

//  CPU-side AXI4 master bridge; feeds the interconnect ahead of each slave wrapper.

---
 rtl/axi_master_wrapper.sv | 160 ++++++++++++++++
 tb/tb_axi_master_wrapper.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_master_wrapper.sv
// rtl/axi_master_wrapper.sv - CPU request to AXI4 master bridge (INCR read bursts, single-beat writes)
// One outstanding transaction; the CPU is stalled until the read's RLAST beat or the write response.
module axi_master_wrapper #(
    parameter int              ID_W      = 4,
    parameter logic [ID_W-1:0] MASTER_ID = '0,
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 32,
    parameter int              LEN_W     = 4,
    localparam int             STRB_W    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              ARSTN,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [LEN_W-1:0]  cpu_len,
    input  logic [STRB_W-1:0] cpu_wstrb,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    output logic [ID_W-1:0]   ARID,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [LEN_W-1:0]  ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [ID_W-1:0]   RID,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY,
    output logic [ID_W-1:0]   AWID,
    output logic [ADDR_W-1:0] AWADDR,
    output logic [LEN_W-1:0]  AWLEN,
    output logic [2:0]        AWSIZE,
    output logic [1:0]        AWBURST,
    output logic              AWVALID,
    input  logic              AWREADY,
    output logic [DATA_W-1:0] WDATA,
    output logic [STRB_W-1:0] WSTRB,
    output logic              WLAST,
    output logic              WVALID,
    input  logic              WREADY,
    input  logic [ID_W-1:0]   BID,
    input  logic [1:0]        BRESP,
    input  logic              BVALID,
    output logic              BREADY
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RADDR = 3'd1,
        RDATA_S = 3'd2,
        WADDR = 3'd3,
        WDATA_S = 3'd4,
        WRESP = 3'd5
    } state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_WORD  = 3'b010;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LEN_W-1:0]    len_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [LEN_W-1:0]    cnt_q;
    logic                err_q;

    logic r_beat;
    logic b_done;
    logic done;

    // VALID/READY are pure state decodes, so the async reset of state_q drops them immediately.
    assign ARVALID = (state_q == RADDR);
    assign RREADY  = (state_q == RDATA_S);
    assign AWVALID = (state_q == WADDR);
    assign WVALID  = (state_q == WDATA_S);
    assign BREADY  = (state_q == WRESP);

    assign ARID    = MASTER_ID;
    assign ARADDR  = addr_q;
    assign ARLEN   = len_q;
    assign ARSIZE  = SIZE_WORD;
    assign ARBURST = BURST_INCR;

    assign AWID    = MASTER_ID;
    assign AWADDR  = addr_q;
    assign AWLEN   = '0;
    assign AWSIZE  = SIZE_WORD;
    assign AWBURST = BURST_INCR;

    assign WDATA   = wdata_q;
    assign WSTRB   = wstrb_q;
    assign WLAST   = 1'b1;

    assign r_beat = RVALID && RREADY && (RID == MASTER_ID);
    assign b_done = BVALID && BREADY && (BID == MASTER_ID);
    assign done   = (r_beat && RLAST) || b_done;

    assign cpu_rvalid = r_beat;
    assign cpu_rdata  = r_beat ? RDATA : '0;
    assign cpu_err    = err_q;
    assign cpu_stall  = ((state_q != IDLE) || cpu_req) && !done;

    always_ff @(posedge clk or negedge ARSTN) begin
        if (!ARSTN) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_req) begin
                        addr_q  <= cpu_addr;
                        len_q   <= cpu_len;
                        wstrb_q <= cpu_wstrb;
                        wdata_q <= cpu_wdata;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                        state_q <= cpu_we ? WADDR : RADDR;
                    end
                end
                RADDR: begin
                    if (ARREADY) state_q <= RDATA_S;
                end
                RDATA_S: begin
                    if (r_beat) begin
                        cnt_q <= cnt_q + 1'b1;
                        // A beat at the expected final index without RLAST means the slave overran ARLEN.
                        if ((RRESP != 2'b00) || ((cnt_q == len_q) && !RLAST)) err_q <= 1'b1;
                        if (RLAST) state_q <= IDLE;
                    end
                end
                WADDR: begin
                    if (AWREADY) state_q <= WDATA_S;
                end
                WDATA_S: begin
                    if (WREADY) state_q <= WRESP;
                end
                WRESP: begin
                    if (b_done) begin
                        if (BRESP != 2'b00) err_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_master_wrapper.sv
// tb/tb_axi_master_wrapper.sv - directed bench for axi_master_wrapper
module tb_axi_master_wrapper;

    logic        clk = 1'b0;
    logic        ARSTN = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [3:0]  cpu_len = '0;
    logic [3:0]  cpu_wstrb = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_stall, cpu_rvalid, cpu_err;
    logic [31:0] cpu_rdata;
    logic [3:0]  ARID, AWID;
    logic [31:0] ARADDR, AWADDR;
    logic [3:0]  ARLEN, AWLEN;
    logic [2:0]  ARSIZE, AWSIZE;
    logic [1:0]  ARBURST, AWBURST;
    logic        ARVALID, AWVALID;
    logic        ARREADY = 1'b0, AWREADY = 1'b0, WREADY = 1'b0;
    logic [3:0]  RID = '0, BID = '0;
    logic [31:0] RDATA = '0;
    logic [1:0]  RRESP = '0, BRESP = '0;
    logic        RLAST = 1'b0, RVALID = 1'b0, BVALID = 1'b0;
    logic        RREADY, BREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST, WVALID;

    int checks = 0;
    int passes = 0;
    int rv_pulses = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (cpu_rvalid === 1'b1) rv_pulses++;

    axi_master_wrapper dut (
        .clk(clk), .ARSTN(ARSTN),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_len(cpu_len),
        .cpu_wstrb(cpu_wstrb), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;

        // reset state
        #12;
        check("rst_stall", cpu_stall, 0);
        check("rst_rvalid", cpu_rvalid, 0);
        check("rst_rdata", cpu_rdata, 0);
        check("rst_err", cpu_err, 0);
        check("rst_valids", {ARVALID, AWVALID, WVALID}, 0);
        check("rst_readys", {RREADY, BREADY}, 0);
        check("rst_araddr", ARADDR, 0);
        tick();
        ARSTN = 1'b1;
        tick();

        // read len=0, zero-wait slave
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; cpu_len = 0;
        #1 check("r0_accept_stall", cpu_stall, 1);
        tick();
        cpu_req = 0; cpu_addr = 32'hFFFF_FFF0; ARREADY = 1;
        #1 check("r0_arvalid", ARVALID, 1);
        check("r0_araddr", ARADDR, 32'h10);
        check("r0_arlen", ARLEN, 0);
        check("r0_arsize_burst", {ARSIZE, ARBURST}, {3'b010, 2'b01});
        check("r0_arid", ARID, 0);
        tick();
        ARREADY = 0; RVALID = 1; RID = 0; RDATA = 32'hDEADBEEF; RLAST = 1; RRESP = 0;
        #1 check("r0_rready", RREADY, 1);
        check("r0_cpu_rvalid", cpu_rvalid, 1);
        check("r0_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        check("r0_stall_done", cpu_stall, 0);
        tick();
        RVALID = 0; RLAST = 0;
        #1 check("r0_idle_rvalid", cpu_rvalid, 0);
        check("r0_idle_rready", RREADY, 0);
        check("r0_idle_err", cpu_err, 0);

        // read len=3, ARREADY late by 2, mismatched RID, 4 beats with gaps
        cpu_req = 1; cpu_addr = 32'h200; cpu_len = 3;
        tick();
        cpu_req = 0; cpu_len = 0;
        #1 check("r3_arvalid_c1", ARVALID, 1);
        tick();
        #1 check("r3_arvalid_c2", ARVALID, 1);
        check("r3_araddr_c2", ARADDR, 32'h200);
        tick();
        ARREADY = 1;
        #1 check("r3_arvalid_c3", ARVALID, 1);
        check("r3_arlen", ARLEN, 3);
        tick();
        ARREADY = 0; RVALID = 1; RID = 4'd5; RDATA = 32'hBAD; RLAST = 1;
        #1 check("badid_rvalid", cpu_rvalid, 0);
        check("badid_stall", cpu_stall, 1);
        tick();
        RVALID = 0; RID = 0; RLAST = 0;
        #1 check("badid_still_rdata", RREADY, 1);
        base = rv_pulses;
        for (int i = 0; i < 4; i++) begin
            RVALID = 1; RDATA = 32'hA0 + i; RLAST = (i == 3);
            #1 check("r3_beat_rvalid", cpu_rvalid, 1);
            check("r3_beat_rdata", cpu_rdata, 32'hA0 + i);
            check("r3_beat_stall", cpu_stall, (i == 3) ? 0 : 1);
            tick();
            RVALID = 0; RLAST = 0;
            if (i < 3) begin
                #1 check("r3_gap_rvalid", cpu_rvalid, 0);
                tick();
            end
        end
        #1 check("r3_pulses", rv_pulses - base, 4);
        check("r3_idle_rready", RREADY, 0);
        check("r3_idle_stall", cpu_stall, 0);
        check("r3_err", cpu_err, 0);

        // write, AWREADY late 2, WREADY late 1, OKAY
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h100; cpu_len = 4'd5;
        cpu_wdata = 32'h1234_5678; cpu_wstrb = 4'b0011;
        tick();
        cpu_req = 0; cpu_wdata = 32'hFFFF_FFFF; cpu_wstrb = 4'b1111;
        #1 check("w_awvalid", AWVALID, 1);
        check("w_awaddr", AWADDR, 32'h100);
        check("w_awlen", AWLEN, 0);
        check("w_awsize_burst", {AWSIZE, AWBURST}, {3'b010, 2'b01});
        tick();
        AWREADY = 1;
        #1 check("w_awvalid_held", AWVALID, 1);
        tick();
        AWREADY = 0;
        #1 check("w_wvalid", WVALID, 1);
        check("w_wlast", WLAST, 1);
        check("w_wdata", WDATA, 32'h1234_5678);
        check("w_wstrb", WSTRB, 4'b0011);
        check("w_awvalid_drop", AWVALID, 0);
        tick();
        WREADY = 1;
        #1 check("w_wvalid_held", WVALID, 1);
        tick();
        WREADY = 0; BVALID = 1; BID = 4'd3; BRESP = 2'b00;
        #1 check("w_bready", BREADY, 1);
        check("w_badbid_stall", cpu_stall, 1);
        tick();
        BID = 0;
        #1 check("w_bdone_stall", cpu_stall, 0);
        tick();
        BVALID = 0;
        #1 check("w_ok_err", cpu_err, 0);
        check("w_idle_bready", BREADY, 0);

        // write with SLVERR, then read clears cpu_err (and trips the overrun check)
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h104;
        tick();
        cpu_req = 0; AWREADY = 1;
        tick();
        AWREADY = 0; WREADY = 1;
        tick();
        WREADY = 0; BVALID = 1; BRESP = 2'b10;
        #1 check("we_done_stall", cpu_stall, 0);
        tick();
        BVALID = 0; BRESP = 0;
        #1 check("we_err_set", cpu_err, 1);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40; cpu_len = 0;
        #1 check("we_err_before_accept", cpu_err, 1);
        tick();
        cpu_req = 0; ARREADY = 1;
        #1 check("we_err_cleared", cpu_err, 0);
        tick();
        ARREADY = 0; RVALID = 1; RDATA = 32'h1; RLAST = 0;
        #1 check("ovr_beat_stall", cpu_stall, 1);
        tick();
        RDATA = 32'h2; RLAST = 1;
        #1 check("ovr_err", cpu_err, 1);
        check("ovr_done_stall", cpu_stall, 0);
        tick();
        RVALID = 0; RLAST = 0;

        // reset asserted during beat 2 of a 4-beat read
        cpu_req = 1; cpu_addr = 32'h300; cpu_len = 3;
        tick();
        cpu_req = 0; ARREADY = 1;
        tick();
        ARREADY = 0; RVALID = 1; RDATA = 32'h11;
        tick();
        RVALID = 0;
        tick();
        RVALID = 1; RDATA = 32'h22;
        #1 check("rst_mid_beat2", cpu_rvalid, 1);
        ARSTN = 0;
        #1 check("rst_mid_rvalid", cpu_rvalid, 0);
        check("rst_mid_rdata", cpu_rdata, 0);
        check("rst_mid_rready", RREADY, 0);
        check("rst_mid_stall", cpu_stall, 0);
        check("rst_mid_addr", ARADDR, 0);
        RVALID = 0;
        tick();
        ARSTN = 1;
        tick();
        cpu_req = 1; cpu_addr = 32'h400; cpu_len = 0;
        #1 check("post_rst_stall", cpu_stall, 1);
        tick();
        cpu_req = 0; ARREADY = 1;
        #1 check("post_rst_arvalid", ARVALID, 1);
        check("post_rst_araddr", ARADDR, 32'h400);
        tick();
        ARREADY = 0; RVALID = 1; RDATA = 32'h55; RLAST = 1;
        #1 check("post_rst_rdata", cpu_rdata, 32'h55);
        tick();
        RVALID = 0; RLAST = 0;
        #1 check("post_rst_idle", cpu_stall, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
